// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: run/step sequencer for a simple core.
//
// The host starts execution in free-run or single-step mode. Execution can
// be stopped by a halt opcode, the instruction budget or a host abort. The
// controller gates PC advance and register-file writes, and counts the
// instructions that commit.
//
// Ports
//   Clk          single clock, rising edge
//   Reset        synchronous, active-high
//   start        begin/restart (honoured in IDLE and HALT only)
//   step_mode    sampled with start: 0 free run, 1 single-step
//   step_req     request one instruction in single-step mode
//   stop_req     host abort (ignored in IDLE, RST, HALT)
//   max_cycles   instruction budget, 0 = unlimited
//   Instr_Code   current fetched instruction
//   pc_en        fetch/PC advance enable (combinational)
//   wr_gate      register-file write gate (combinational)
//   core_rst     one-cycle datapath reset, high in RST
//   step_ack     stepped instruction committed (combinational)
//   busy         high in RUN, STEP_WAIT, STEP_EXEC
//   halted       high in HALT
//   halt_cause   00 none, 01 halt opcode, 10 budget, 11 stop
//   instr_count  committed instructions since last start, saturating
//
// state     | meaning
// IDLE      | after reset, nothing running
// RST       | one-cycle datapath reset before execution
// RUN       | free run, one instruction per cycle
// STEP_WAIT | single-step, waiting for step_req
// STEP_EXEC | single-step, executing one instruction
// HALT      | stopped, halt_cause valid until next start

module core_seq_ctrl (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic        step_mode,
  input  logic        step_req,
  input  logic        stop_req,
  input  logic [15:0] max_cycles,
  input  logic [31:0] Instr_Code,
  output logic        pc_en,
  output logic        wr_gate,
  output logic        core_rst,
  output logic        step_ack,
  output logic        busy,
  output logic        halted,
  output logic [1:0]  halt_cause,
  output logic [15:0] instr_count
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RST       = 3'd1;
  localparam logic [2:0] S_RUN       = 3'd2;
  localparam logic [2:0] S_STEP_WAIT = 3'd3;
  localparam logic [2:0] S_STEP_EXEC = 3'd4;
  localparam logic [2:0] S_HALT      = 3'd5;

  localparam logic [1:0] CAUSE_NONE   = 2'b00;
  localparam logic [1:0] CAUSE_OPCODE = 2'b01;
  localparam logic [1:0] CAUSE_BUDGET = 2'b10;
  localparam logic [1:0] CAUSE_STOP   = 2'b11;

  logic [2:0]  state_q, state_d;
  logic [1:0]  cause_q, cause_d;
  logic [15:0] count_q, count_d;
  logic        step_mode_q, step_mode_d;

  logic        halt_op;
  logic        commit;
  logic [16:0] count_inc;
  logic        budget_hit;

  assign halt_op = (Instr_Code[31:26] == 6'b111111);

  // 17-bit compare so a saturated count never aliases a budget value.
  assign count_inc  = {1'b0, count_q} + 17'd1;
  assign budget_hit = (max_cycles != 16'd0) && (count_inc == {1'b0, max_cycles});

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    count_d     = count_q;
    step_mode_d = step_mode_q;
    commit      = 1'b0;
    case (state_q)
      S_IDLE, S_HALT: begin
        // Clearing on entry makes RST already show a clean count and cause.
        if (start) begin
          state_d     = S_RST;
          cause_d     = CAUSE_NONE;
          count_d     = 16'd0;
          step_mode_d = step_mode;
        end
      end
      S_RST: begin
        state_d = step_mode_q ? S_STEP_WAIT : S_RUN;
      end
      S_RUN: begin
        if (halt_op) begin
          state_d = S_HALT;
          cause_d = CAUSE_OPCODE;
        end else if (stop_req) begin
          state_d = S_HALT;
          cause_d = CAUSE_STOP;
        end else begin
          commit = 1'b1;
          if (budget_hit) begin
            state_d = S_HALT;
            cause_d = CAUSE_BUDGET;
          end
        end
      end
      S_STEP_WAIT: begin
        if (stop_req) begin
          state_d = S_HALT;
          cause_d = CAUSE_STOP;
        end else if (step_req) begin
          state_d = S_STEP_EXEC;
        end
      end
      S_STEP_EXEC: begin
        if (halt_op) begin
          state_d = S_HALT;
          cause_d = CAUSE_OPCODE;
        end else begin
          commit = 1'b1;
          if (budget_hit) begin
            state_d = S_HALT;
            cause_d = CAUSE_BUDGET;
          end else begin
            state_d = S_STEP_WAIT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (commit && (count_q != 16'hFFFF)) begin
      count_d = count_inc[15:0];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      cause_q     <= CAUSE_NONE;
      count_q     <= 16'd0;
      step_mode_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      count_q     <= count_d;
      step_mode_q <= step_mode_d;
    end
  end

  assign pc_en       = commit;
  assign wr_gate     = commit;
  assign step_ack    = commit && (state_q == S_STEP_EXEC);
  assign core_rst    = (state_q == S_RST);
  assign busy        = (state_q == S_RUN) || (state_q == S_STEP_WAIT) ||
                       (state_q == S_STEP_EXEC);
  assign halted      = (state_q == S_HALT);
  assign halt_cause  = cause_q;
  assign instr_count = count_q;

endmodule

// File: doc/core_seq_ctrl.md
CORE_SEQ_CTRL -- requirements
Module: core_seq_ctrl

Interface
REQ-001 SHALL have port Clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port Reset, input, 1, synchronous, active-high.
REQ-003 SHALL have port start, input, 1, begin or restart execution.
REQ-004 SHALL have port step_mode, input, 1, sampled with start: 0 = free run, 1 = single-step.
REQ-005 SHALL have port step_req, input, 1, request one instruction in single-step mode.
REQ-006 SHALL have port stop_req, input, 1, host abort.
REQ-007 SHALL have port max_cycles, input, 16, instruction budget; 0 = unlimited.
REQ-008 SHALL have port Instr_Code, input, 32, current fetched instruction.
REQ-009 SHALL have port pc_en, output, 1, fetch/PC advance enable.
REQ-010 SHALL have port wr_gate, output, 1, AND-gate for register-file Reg_Write.
REQ-011 SHALL have port core_rst, output, 1, one-cycle datapath reset pulse.
REQ-012 SHALL have port step_ack, output, 1, pulse: stepped instruction committed.
REQ-013 SHALL have port busy, output, 1, high in RUN, STEP_WAIT, STEP_EXEC.
REQ-014 SHALL have port halted, output, 1, high in HALT.
REQ-015 SHALL have port halt_cause, output, 2: 00 none, 01 halt opcode, 10 budget, 11 stop.
REQ-016 SHALL have port instr_count, output, 16, committed instructions since last start.

Function
REQ-017 SHALL implement states IDLE, RST, RUN, STEP_WAIT, STEP_EXEC, HALT; all outputs registered or decoded from state only, except pc_en/wr_gate/step_ack, which are gated combinationally as stated below.
REQ-018 SHALL define halt opcode as Instr_Code[31:26] == 6'b111111.
REQ-019 IDLE or HALT with start=1 SHALL go to RST; start in any other state is ignored.
REQ-020 RST SHALL last exactly one cycle with core_rst=1, clear instr_count and halt_cause, latch step_mode, then go to RUN (step_mode=0) or STEP_WAIT (step_mode=1).
REQ-021 In RUN, pc_en=wr_gate=1 and instr_count increments by 1 each cycle unless a halt condition holds in that cycle.
REQ-022 RUN halt priority per cycle: halt opcode (01) > stop_req (11); on either, pc_en=wr_gate=0, no increment, next state HALT.
REQ-023 Budget: when max_cycles != 0 and instruction commits with instr_count+1 == max_cycles, that instruction SHALL commit and next state SHALL be HALT with cause 10.
REQ-024 STEP_WAIT SHALL hold pc_en=wr_gate=0; stop_req -> HALT (11); else step_req -> STEP_EXEC; stop_req wins over simultaneous step_req.
REQ-025 STEP_EXEC SHALL last one cycle: if halt opcode -> pc_en=wr_gate=0, HALT (01), step_ack=0; else pc_en=wr_gate=1, step_ack=1, instr_count+1, budget check per REQ-023, else back to STEP_WAIT.
REQ-026 step_req held high SHALL advance one instruction per two cycles (STEP_WAIT/STEP_EXEC alternation).
REQ-027 instr_count SHALL saturate at 16'hFFFF, no wrap.
REQ-028 halt_cause SHALL hold its value in HALT until next RST.
REQ-029 stop_req in IDLE, RST or HALT SHALL be ignored.

Reset
REQ-030 Reset=1 SHALL, at the next edge, force IDLE, instr_count=0, halt_cause=00, step_mode latch=0, overriding any state incl. mid-RUN or RST.
REQ-031 While in IDLE after reset: pc_en=wr_gate=core_rst=step_ack=busy=halted=0.

Verification
REQ-032 Reset, start (step_mode=0, max_cycles=0), 5 normal instrs then opcode 111111 -> core_rst 1 cycle, pc_en high 5 cycles, halted=1, halt_cause=01, instr_count=5.
REQ-033 max_cycles=3, free run of normal instrs -> exactly 3 commits, HALT, halt_cause=10, instr_count=3.
REQ-034 step_mode=1, two step_req pulses -> two step_ack pulses, instr_count=2, pc_en high only in STEP_EXEC cycles; stop_req+step_req same cycle -> HALT cause 11, no commit.
REQ-035 stop_req in 4th RUN cycle -> 3 commits, wr_gate=0 that cycle, halt_cause=11; then start -> RST pulse, halt_cause=00, instr_count=0.
REQ-036 Reset asserted mid-RUN with instr_count=7 -> next cycle IDLE, all outputs 0, instr_count=0.
REQ-037 Force instr_count to 16'hFFFE, max_cycles=0, run 3 more instrs -> instr_count=16'hFFFF, no wrap.
